// File: rtl/riscv_dift_policy_csr.sv
// DIFT tag-policy CSR block: active/staged TPR and TCR, a drain-gated atomic commit,
// and capture of the first tag violation with a saturating overflow counter.
module riscv_dift_policy_csr #(
  parameter logic [11:0] TPR_ADDR   = 12'h7C0,
  parameter logic [11:0] TCR_ADDR   = 12'h7C1,
  parameter logic [11:0] VSTAT_ADDR = 12'h7C2,
  parameter logic [11:0] VPC_ADDR   = 12'h7C3,
  parameter logic [17:0] TPR_RESET  = 18'h0,
  parameter logic [22:0] TCR_RESET  = 23'h0,
  parameter int unsigned OVF_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_req_i,
  output logic        csr_gnt_o,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_rvalid_o,
  output logic [31:0] csr_rdata_o,
  output logic        csr_err_o,
  input  logic        pipe_idle_i,
  output logic [17:0] tpr_o,
  output logic [22:0] tcr_o,
  output logic        policy_update_o,
  input  logic        chk_valid_i,
  input  logic [22:0] chk_violation_i,
  input  logic [31:0] chk_pc_i,
  output logic        exc_req_o,
  input  logic        exc_ack_i
);

  localparam logic [1:0]  CsrOpNone  = 2'd0;
  localparam logic [1:0]  CsrOpWrite = 2'd1;
  localparam logic [1:0]  CsrOpSet   = 2'd2;
  // Bit 14 of TPR is reserved and always stored as 0.
  localparam logic [17:0] TprMask    = 18'h3BFFF;

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e               state_q, state_d;
  logic [22:0]          shadow_q, shadow_d;
  logic                 tgt_tcr_q, tgt_tcr_d;
  logic [17:0]          tpr_q, tpr_d;
  logic [22:0]          tcr_q, tcr_d;
  logic                 upd_q, upd_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 exc_q, exc_d;
  logic [4:0]           cause_q, cause_d;
  logic [31:0]          vpc_q, vpc_d;
  logic [OVF_WIDTH-1:0] ovf_q, ovf_d;

  logic        accept, wr, is_tpr, is_tcr, is_vstat, is_vpc;
  logic [31:0] old_val, new_val;
  logic [22:0] masked;
  logic        hit;
  logic [4:0]  first_idx;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    tgt_tcr_d = tgt_tcr_q;
    tpr_d     = tpr_q;
    tcr_d     = tcr_q;
    upd_d     = 1'b0;
    rvalid_d  = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;
    exc_d     = exc_q;
    cause_d   = cause_q;
    vpc_d     = vpc_q;
    ovf_d     = ovf_q;

    accept   = csr_req_i & (state_q == StIdle);
    wr       = (csr_op_i != CsrOpNone);
    is_tpr   = (csr_addr_i == TPR_ADDR);
    is_tcr   = (csr_addr_i == TCR_ADDR);
    is_vstat = (csr_addr_i == VSTAT_ADDR);
    is_vpc   = (csr_addr_i == VPC_ADDR);

    old_val = '0;
    if (is_tpr)        old_val = 32'(tpr_q);
    else if (is_tcr)   old_val = 32'(tcr_q);
    else if (is_vstat) old_val = 32'({ovf_q, 2'b00, exc_q, cause_q});
    else if (is_vpc)   old_val = vpc_q;

    if (csr_op_i == CsrOpWrite)    new_val = csr_wdata_i;
    else if (csr_op_i == CsrOpSet) new_val = old_val | csr_wdata_i;
    else                           new_val = old_val & ~csr_wdata_i;

    if (accept) begin
      rvalid_d = 1'b1;
      if ((is_tpr || is_tcr || is_vstat || is_vpc) && !(is_vpc && wr)) rdata_d = old_val;
      else                                                              err_d   = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept && wr && (is_tpr || is_tcr)) begin
          shadow_d  = is_tpr ? {5'b0, new_val[17:0] & TprMask} : new_val[22:0];
          tgt_tcr_d = is_tcr;
          state_d   = StPending;
        end
      end
      StPending: begin
        if (pipe_idle_i) begin
          if (tgt_tcr_q) tcr_d = shadow_q;
          else           tpr_d = shadow_q[17:0];
          upd_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // The violation mask always uses the currently active TCR.
    masked    = chk_violation_i & tcr_q;
    hit       = chk_valid_i & (|masked);
    first_idx = '0;
    for (int i = 22; i >= 0; i--) begin
      if (masked[i]) first_idx = 5'(i);
    end

    if (hit && (!exc_q || exc_ack_i)) begin
      cause_d = first_idx;
      vpc_d   = chk_pc_i;
      exc_d   = 1'b1;
    end else if (hit) begin
      if (ovf_q != {OVF_WIDTH{1'b1}}) ovf_d = ovf_q + OVF_WIDTH'(1);
    end else if (exc_ack_i) begin
      exc_d = 1'b0;
    end

    if (accept && wr && is_vstat) ovf_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      tgt_tcr_q <= 1'b0;
      tpr_q     <= TPR_RESET;
      tcr_q     <= TCR_RESET;
      upd_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      exc_q     <= 1'b0;
      cause_q   <= '0;
      vpc_q     <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      tgt_tcr_q <= tgt_tcr_d;
      tpr_q     <= tpr_d;
      tcr_q     <= tcr_d;
      upd_q     <= upd_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      exc_q     <= exc_d;
      cause_q   <= cause_d;
      vpc_q     <= vpc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign csr_gnt_o       = (state_q == StIdle);
  assign csr_rvalid_o    = rvalid_q;
  assign csr_rdata_o     = rdata_q;
  assign csr_err_o       = err_q;
  assign tpr_o           = tpr_q;
  assign tcr_o           = tcr_q;
  assign policy_update_o = upd_q;
  assign exc_req_o       = exc_q;

endmodule

// File: tb/tb_riscv_dift_policy_csr.sv
// Bench for riscv_dift_policy_csr: directed scenarios plus random traffic, all checked
// every cycle against a behavioural policy/violation model.
module tb_riscv_dift_policy_csr;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_req_i;
  logic        csr_gnt_o;
  logic [11:0] csr_addr_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_wdata_i;
  logic        csr_rvalid_o;
  logic [31:0] csr_rdata_o;
  logic        csr_err_o;
  logic        pipe_idle_i;
  logic [17:0] tpr_o;
  logic [22:0] tcr_o;
  logic        policy_update_o;
  logic        chk_valid_i;
  logic [22:0] chk_violation_i;
  logic [31:0] chk_pc_i;
  logic        exc_req_o;
  logic        exc_ack_i;

  riscv_dift_policy_csr dut (
    .clk             (clk),
    .rst             (rst),
    .csr_req_i       (csr_req_i),
    .csr_gnt_o       (csr_gnt_o),
    .csr_addr_i      (csr_addr_i),
    .csr_op_i        (csr_op_i),
    .csr_wdata_i     (csr_wdata_i),
    .csr_rvalid_o    (csr_rvalid_o),
    .csr_rdata_o     (csr_rdata_o),
    .csr_err_o       (csr_err_o),
    .pipe_idle_i     (pipe_idle_i),
    .tpr_o           (tpr_o),
    .tcr_o           (tcr_o),
    .policy_update_o (policy_update_o),
    .chk_valid_i     (chk_valid_i),
    .chk_violation_i (chk_violation_i),
    .chk_pc_i        (chk_pc_i),
    .exc_req_o       (exc_req_o),
    .exc_ack_i       (exc_ack_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [31:0] m_tpr, m_tcr, m_shadow, m_rdata, m_vpc;
  bit          m_busy, m_tgt_tcr, m_upd, m_rvalid, m_err, m_exc;
  int          m_cause, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] apply_op(input int op, input logic [31:0] old,
                                           input logic [31:0] w);
    case (op)
      1:       return w;
      2:       return old | w;
      default: return old & ~w;
    endcase
  endfunction

  task automatic model_step();
    bit          acc, wr, known, hit;
    logic [31:0] old, masked, nv;
    int          first;
    if (rst) begin
      m_tpr = 0; m_tcr = 0; m_shadow = 0; m_busy = 0; m_tgt_tcr = 0; m_upd = 0;
      m_rvalid = 0; m_rdata = 0; m_err = 0; m_exc = 0; m_cause = 0; m_vpc = 0; m_ovf = 0;
      return;
    end
    acc    = csr_req_i && !m_busy;
    wr     = csr_op_i != 0;
    masked = {9'b0, chk_violation_i} & m_tcr;
    hit    = chk_valid_i && (masked != 0);
    first  = 0;
    for (int i = 0; i < 23; i++) if (masked[i]) begin first = i; break; end

    known = 1; old = 0;
    case (csr_addr_i)
      12'h7C0: old = m_tpr;
      12'h7C1: old = m_tcr;
      12'h7C2: old = m_cause + (m_exc ? 32 : 0) + m_ovf * 256;
      12'h7C3: old = m_vpc;
      default: known = 0;
    endcase
    m_rvalid = acc;
    m_rdata  = 0;
    m_err    = 0;
    if (acc) begin
      if (!known || (csr_addr_i == 12'h7C3 && wr)) m_err = 1;
      else m_rdata = old;
    end

    m_upd = 0;
    if (m_busy && pipe_idle_i) begin
      if (m_tgt_tcr) m_tcr = m_shadow; else m_tpr = m_shadow;
      m_busy = 0;
      m_upd  = 1;
    end else if (acc && wr && (csr_addr_i == 12'h7C0 || csr_addr_i == 12'h7C1)) begin
      nv        = apply_op(int'(csr_op_i), old, csr_wdata_i);
      m_tgt_tcr = csr_addr_i == 12'h7C1;
      m_shadow  = m_tgt_tcr ? (nv & 32'h7FFFFF) : (nv & 32'h3FFFF & ~32'h4000);
      m_busy    = 1;
    end

    if (hit && (!m_exc || exc_ack_i)) begin
      m_cause = first; m_vpc = chk_pc_i; m_exc = 1;
    end else if (hit) begin
      if (m_ovf < 255) m_ovf++;
    end else if (exc_ack_i) begin
      m_exc = 0;
    end
    if (acc && wr && csr_addr_i == 12'h7C2) m_ovf = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("gnt", 32'(csr_gnt_o), 32'(!m_busy));
    chk("rvalid", 32'(csr_rvalid_o), 32'(m_rvalid));
    if (m_rvalid) begin
      chk("rdata", csr_rdata_o, m_rdata);
      chk("err", 32'(csr_err_o), 32'(m_err));
    end
    chk("tpr", 32'(tpr_o), m_tpr);
    chk("tcr", 32'(tcr_o), m_tcr);
    chk("policy_update", 32'(policy_update_o), 32'(m_upd));
    chk("exc_req", 32'(exc_req_o), 32'(m_exc));
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w,
                     output logic [31:0] rd, output logic er);
    csr_req_i = 1; csr_addr_i = a; csr_op_i = op; csr_wdata_i = w;
    cycle();
    chk("lit_rvalid", 32'(csr_rvalid_o), 32'h1);
    rd = csr_rdata_o;
    er = csr_err_o;
    csr_req_i = 0; csr_op_i = 0; csr_wdata_i = 0;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst = 1; csr_req_i = 0; csr_addr_i = 0; csr_op_i = 0; csr_wdata_i = 0;
    pipe_idle_i = 0; chk_valid_i = 0; chk_violation_i = 0; chk_pc_i = 0; exc_ack_i = 0;
    cycle(); cycle();
    rst = 0;
    chk("reset_gnt", 32'(csr_gnt_o), 32'h1);
    chk("reset_exc", 32'(exc_req_o), 32'h0);

    // 1: staged TPR write held off until the pipeline drains
    csr(12'h7C0, 2'd1, 32'h0000F, rd, er);
    chk("t1_rdata", rd, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t1_gnt_low", 32'(csr_gnt_o), 32'h0);
      chk("t1_tpr_hold", 32'(tpr_o), 32'h0);
    end
    pipe_idle_i = 1;
    cycle();
    chk("t1_tpr", 32'(tpr_o), 32'h0000F);
    chk("t1_model_tpr", m_tpr, 32'h0000F);
    chk("t1_upd", 32'(policy_update_o), 32'h1);
    cycle();
    chk("t1_upd_once", 32'(policy_update_o), 32'h0);

    // 2: SET / CLEAR / NONE on TCR
    csr(12'h7C1, 2'd1, 32'h3, rd, er); cycle();
    csr(12'h7C1, 2'd2, 32'h4, rd, er); cycle();
    chk("t2_set", 32'(tcr_o), 32'h7);
    csr(12'h7C1, 2'd3, 32'h1, rd, er); cycle();
    chk("t2_clear", 32'(tcr_o), 32'h6);
    chk("t2_model_tcr", m_tcr, 32'h6);
    csr(12'h7C1, 2'd0, 32'h0, rd, er);
    chk("t2_none_rdata", rd, 32'h6);
    chk("t2_none_idle", 32'(csr_gnt_o), 32'h1);

    // 3: first violation captured
    chk_valid_i = 1; chk_violation_i = 23'h00000C; chk_pc_i = 32'h1000;
    cycle();
    chk_valid_i = 0;
    chk("t3_exc", 32'(exc_req_o), 32'h1);
    csr(12'h7C2, 2'd0, 32'h0, rd, er);
    chk("t3_cause", {27'b0, rd[4:0]}, 32'h2);
    chk("t3_model_cause", 32'(m_cause), 32'h2);
    csr(12'h7C3, 2'd0, 32'h0, rd, er);
    chk("t3_vpc", rd, 32'h1000);

    // 4: overflow saturation, then ack coinciding with a new hit
    chk_valid_i = 1; chk_violation_i = 23'h4;
    for (int i = 0; i < 300; i++) begin chk_pc_i = $urandom; cycle(); end
    chk_valid_i = 0;
    csr(12'h7C2, 2'd0, 32'h0, rd, er);
    chk("t4_ovf_sat", {24'b0, rd[15:8]}, 32'hFF);
    chk("t4_model_ovf", 32'(m_ovf), 32'hFF);
    chk_valid_i = 1; chk_violation_i = 23'h2; chk_pc_i = 32'h2000; exc_ack_i = 1;
    cycle();
    chk_valid_i = 0; exc_ack_i = 0;
    chk("t4_exc_stays", 32'(exc_req_o), 32'h1);
    csr(12'h7C2, 2'd0, 32'h0, rd, er);
    chk("t4_new_cause", {27'b0, rd[4:0]}, 32'h1);
    csr(12'h7C3, 2'd0, 32'h0, rd, er);
    chk("t4_new_vpc", rd, 32'h2000);
    csr(12'h7C2, 2'd1, 32'h0, rd, er);
    csr(12'h7C2, 2'd0, 32'h0, rd, er);
    chk("t4_ovf_cleared", {16'b0, rd[15:0]}, 32'h0021);
    exc_ack_i = 1; cycle(); exc_ack_i = 0;
    chk("t4_ack", 32'(exc_req_o), 32'h0);

    // 5: error responses
    csr(12'h7C9, 2'd0, 32'h0, rd, er);
    chk("t5_err", 32'(er), 32'h1);
    chk("t5_rdata", rd, 32'h0);
    csr(12'h7C3, 2'd1, 32'hDEAD, rd, er);
    chk("t5_vpc_wr_err", 32'(er), 32'h1);
    csr(12'h7C3, 2'd0, 32'h0, rd, er);
    chk("t5_vpc_kept", rd, 32'h2000);

    // 6: reset while a write is pending
    pipe_idle_i = 0;
    csr(12'h7C1, 2'd1, 32'h7FFFFF, rd, er);
    rst = 1; cycle(); rst = 0;
    chk("t6_tcr", 32'(tcr_o), 32'h0);
    chk("t6_gnt", 32'(csr_gnt_o), 32'h1);
    pipe_idle_i = 1;
    cycle();
    chk("t6_no_upd", 32'(policy_update_o), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      csr_req_i       = $urandom_range(0, 1);
      csr_addr_i      = ($urandom_range(0, 9) == 0) ? 12'h7C9 : 12'(12'h7C0 + $urandom_range(0, 3));
      csr_op_i        = 2'($urandom_range(0, 3));
      csr_wdata_i     = $urandom;
      pipe_idle_i     = ($urandom_range(0, 3) != 0);
      chk_valid_i     = $urandom_range(0, 1);
      chk_violation_i = 23'($urandom) & 23'($urandom);
      chk_pc_i        = $urandom;
      exc_ack_i       = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
